// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkg
//  Description : Shared definitions for the AXI-Stream delay line. A beat is
//                flattened into one vector so that every pipeline stage and
//                the skid buffer hold it in a single register.
//                Beat layout, LSB first:
//                  [data | strb | keep | user | last]
//                The functions below give the width of that vector and the
//                LSB position of every field. The pack/unpack concatenations
//                and slices in the top level are built from them.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  localparam int unsigned AXIS_BYTE_W = 8;

  // Total flattened width: data + strb + keep + user + last.
  function automatic int unsigned beat_width(input int unsigned data_w,
                                             input int unsigned user_w);
    return data_w + 2 * (data_w / AXIS_BYTE_W) + user_w + 1;
  endfunction

  function automatic int unsigned strb_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned keep_lsb(input int unsigned data_w);
    return data_w + data_w / AXIS_BYTE_W;
  endfunction

  function automatic int unsigned user_lsb(input int unsigned data_w);
    return data_w + 2 * (data_w / AXIS_BYTE_W);
  endfunction

  function automatic int unsigned last_idx(input int unsigned data_w,
                                           input int unsigned user_w);
    return beat_width(data_w, user_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : axis_reg_slice
//  Description : One stage of the delay line: a valid bit and a flattened
//                beat register. The stage advances when the stage after it
//                advances or when it is empty. An empty stage therefore never
//                blocks the stages in front of it.
//  Ports       : clk_i, rst_n_i    clock, synchronous active-low reset
//                in_valid_i/beat_i  beat offered by the previous stage
//                adv_next_i         advance of the next stage (sink ready
//                                   at the last stage)
//                adv_o              this stage's advance, sent upstream
//                valid_o/beat_o     registered stage contents
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_slice #(
  parameter int unsigned BEAT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [BEAT_W-1:0] in_beat_i,
  input  logic              adv_next_i,
  output logic              adv_o,
  output logic              valid_o,
  output logic [BEAT_W-1:0] beat_o
);

  logic              valid_d, valid_q;
  logic [BEAT_W-1:0] beat_d, beat_q;

  assign adv_o   = adv_next_i | ~valid_q;
  assign valid_o = valid_q;
  assign beat_o  = beat_q;

  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (adv_o) begin
      valid_d = in_valid_i;
      beat_d  = in_beat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is deliberately not reset; only the valid bit qualifies it.
  always_ff @(posedge clk_i) begin
    beat_q <= beat_d;
  end

endmodule
`default_nettype wire

// File: rtl/axis_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : axis_delay_line
//  Description : AXI-Stream delay line. Every beat spends at least DELAY_NR
//                register stages inside the block before it is presented
//                downstream. Full backpressure is supported, bubbles
//                collapse, and the current occupancy is reported.
//  Ports       : clk_i, rst_n_i   clock, synchronous active-low reset
//                s_axis_*         upstream AXIS slave (tvalid, tdata, tstrb,
//                                 tkeep, tuser, tlast, tready)
//                m_axis_*         downstream AXIS master (same signals)
//                occupancy_o      number of beats currently held
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_delay_line
  import axis_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 64,
  parameter int unsigned AXIS_USER_WIDTH = 1,
  parameter int unsigned DELAY_NR        = 1,
  parameter int unsigned READY_REG       = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           s_axis_tvalid,
  input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [AXIS_USER_WIDTH-1:0]     s_axis_tuser,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [AXIS_USER_WIDTH-1:0]     m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic [$clog2(DELAY_NR+2)-1:0]  occupancy_o
);

  localparam int unsigned BEAT_W   = beat_width(AXIS_DATA_WIDTH, AXIS_USER_WIDTH);
  localparam int unsigned STRB_W   = AXIS_DATA_WIDTH / AXIS_BYTE_W;
  localparam int unsigned STRB_LSB = strb_lsb(AXIS_DATA_WIDTH);
  localparam int unsigned KEEP_LSB = keep_lsb(AXIS_DATA_WIDTH);
  localparam int unsigned USER_LSB = user_lsb(AXIS_DATA_WIDTH);
  localparam int unsigned LAST_IDX = last_idx(AXIS_DATA_WIDTH, AXIS_USER_WIDTH);
  localparam int unsigned OCC_W    = $clog2(DELAY_NR + 2);

  if (DELAY_NR == 0) begin : g_bad_delay
    $error("axis_delay_line: DELAY_NR must be 1 or more");
  end
  if (READY_REG > 1) begin : g_bad_ready_reg
    $error("axis_delay_line: READY_REG must be 0 or 1");
  end

  // Pack the upstream beat into the flattened layout.
  logic [BEAT_W-1:0] s_beat;
  assign s_beat = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tstrb, s_axis_tdata};

  logic [DELAY_NR-1:0] stage_valid;
  logic [BEAT_W-1:0]   stage_beat [DELAY_NR];
  // adv[i] is the advance of stage i; adv[DELAY_NR] is the sink's ready.
  logic [DELAY_NR:0]   adv;
  logic                stage0_in_valid;
  logic [BEAT_W-1:0]   stage0_in_beat;

  assign adv[DELAY_NR] = m_axis_tready;

  for (genvar gi = 0; gi < DELAY_NR; gi++) begin : g_stage
    logic              in_valid;
    logic [BEAT_W-1:0] in_beat;

    if (gi == 0) begin : g_first
      assign in_valid = stage0_in_valid;
      assign in_beat  = stage0_in_beat;
    end else begin : g_chain
      assign in_valid = stage_valid[gi-1];
      assign in_beat  = stage_beat[gi-1];
    end

    axis_reg_slice #(
      .BEAT_W     (BEAT_W)
    ) u_slice (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .in_valid_i (in_valid),
      .in_beat_i  (in_beat),
      .adv_next_i (adv[gi+1]),
      .adv_o      (adv[gi]),
      .valid_o    (stage_valid[gi]),
      .beat_o     (stage_beat[gi])
    );
  end

  if (READY_REG == 0) begin : g_comb_ready
    // Ready follows the advance chain, so the sink's ready reaches the source
    // in the same cycle.
    assign s_axis_tready   = adv[0] & rst_n_i;
    assign stage0_in_valid = s_axis_tvalid;
    assign stage0_in_beat  = s_beat;
  end else begin : g_skid
    logic              skid_valid_d, skid_valid_q;
    logic              ready_d, ready_q;
    logic [BEAT_W-1:0] skid_beat_d, skid_beat_q;
    logic              in_accept;

    assign s_axis_tready = ready_q & rst_n_i;
    assign in_accept     = s_axis_tvalid & s_axis_tready;

    // A held skid beat always goes first. Ready is low whenever the skid is
    // full, so a new beat cannot overtake it.
    assign stage0_in_valid = skid_valid_q | in_accept;
    assign stage0_in_beat  = skid_valid_q ? skid_beat_q : s_beat;

    always_comb begin
      skid_valid_d = (skid_valid_q | in_accept) & ~adv[0];
      ready_d      = ~skid_valid_d;
      skid_beat_d  = skid_beat_q;
      if (in_accept && !adv[0]) begin
        skid_beat_d = s_beat;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b0;
      end else begin
        skid_valid_q <= skid_valid_d;
        ready_q      <= ready_d;
      end
    end

    always_ff @(posedge clk_i) begin
      skid_beat_q <= skid_beat_d;
    end
  end

  // Unpack the last stage onto the downstream interface.
  logic [BEAT_W-1:0] out_beat;
  assign out_beat      = stage_beat[DELAY_NR-1];
  assign m_axis_tvalid = stage_valid[DELAY_NR-1] & rst_n_i;
  assign m_axis_tdata  = out_beat[AXIS_DATA_WIDTH-1:0];
  assign m_axis_tstrb  = out_beat[STRB_LSB +: STRB_W];
  assign m_axis_tkeep  = out_beat[KEEP_LSB +: STRB_W];
  assign m_axis_tuser  = out_beat[USER_LSB +: AXIS_USER_WIDTH];
  assign m_axis_tlast  = out_beat[LAST_IDX];

  // Occupancy counter.
  logic             s_accept, m_accept;
  logic [OCC_W-1:0] occ_d, occ_q;

  assign s_accept = s_axis_tvalid & s_axis_tready;
  assign m_accept = m_axis_tvalid & m_axis_tready;

  always_comb begin
    occ_d = occ_q;
    if (s_accept && !m_accept) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!s_accept && m_accept) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = rst_n_i ? occ_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_axis_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_delay_line
//  Description : Self-checking bench for axis_delay_line. Two DELAY_NR=4
//                instances (READY_REG 0 and 1) run a vector table and
//                directed sequences. Four more instances (DELAY_NR 1 and 7,
//                both READY_REG values) run random traffic against a queue
//                based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_delay_line;

  localparam int DW     = 64;
  localparam int SW     = DW / 8;
  localparam int BW     = DW + 2 * SW + 2;
  localparam int NBEATS = 10000;
  localparam int BUDGET = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic start_rand = 1'b0;
  logic rand_done [4];

  // Sidebands are a fixed function of tdata so misalignment is visible.
  function automatic logic [SW-1:0] f_strb(input logic [DW-1:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [SW-1:0] f_keep(input logic [DW-1:0] d);
    return ~d[15:8];
  endfunction
  function automatic logic f_user(input logic [DW-1:0] d);
    return ^d;
  endfunction
  function automatic logic [BW-1:0] mk_beat(input logic [DW-1:0] d, input logic last);
    return {last, f_user(d), f_keep(d), f_strb(d), d};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed instances: index 0 = READY_REG 0, index 1 = READY_REG 1.
  // --------------------------------------------------------------------------
  logic          d_sv [2], d_sr [2], d_sl [2], d_su [2];
  logic          d_mv [2], d_mr [2], d_ml [2], d_mu [2];
  logic [DW-1:0] d_sd [2], d_md [2];
  logic [SW-1:0] d_ss [2], d_sk [2], d_ms [2], d_mk [2];
  logic [2:0]    d_occ [2];

  axis_delay_line #(
    .AXIS_DATA_WIDTH (DW), .AXIS_USER_WIDTH (1), .DELAY_NR (4), .READY_REG (0)
  ) u_dut_a (
    .clk_i (clk), .rst_n_i (rst_n),
    .s_axis_tvalid (d_sv[0]), .s_axis_tdata (d_sd[0]), .s_axis_tstrb (d_ss[0]),
    .s_axis_tkeep (d_sk[0]), .s_axis_tuser (d_su[0]), .s_axis_tlast (d_sl[0]),
    .s_axis_tready (d_sr[0]),
    .m_axis_tvalid (d_mv[0]), .m_axis_tready (d_mr[0]), .m_axis_tdata (d_md[0]),
    .m_axis_tstrb (d_ms[0]), .m_axis_tkeep (d_mk[0]), .m_axis_tuser (d_mu[0]),
    .m_axis_tlast (d_ml[0]), .occupancy_o (d_occ[0])
  );

  axis_delay_line #(
    .AXIS_DATA_WIDTH (DW), .AXIS_USER_WIDTH (1), .DELAY_NR (4), .READY_REG (1)
  ) u_dut_b (
    .clk_i (clk), .rst_n_i (rst_n),
    .s_axis_tvalid (d_sv[1]), .s_axis_tdata (d_sd[1]), .s_axis_tstrb (d_ss[1]),
    .s_axis_tkeep (d_sk[1]), .s_axis_tuser (d_su[1]), .s_axis_tlast (d_sl[1]),
    .s_axis_tready (d_sr[1]),
    .m_axis_tvalid (d_mv[1]), .m_axis_tready (d_mr[1]), .m_axis_tdata (d_md[1]),
    .m_axis_tstrb (d_ms[1]), .m_axis_tkeep (d_mk[1]), .m_axis_tuser (d_mu[1]),
    .m_axis_tlast (d_ml[1]), .occupancy_o (d_occ[1])
  );

  task automatic drv(input int i, input logic v, input logic [DW-1:0] d,
                     input logic last, input logic mr);
    d_sv[i] = v;
    d_sd[i] = d;
    d_ss[i] = f_strb(d);
    d_sk[i] = f_keep(d);
    d_su[i] = f_user(d);
    d_sl[i] = last;
    d_mr[i] = mr;
  endtask

  function automatic logic [BW-1:0] out_beat(input int i);
    return {d_ml[i], d_mu[i], d_mk[i], d_ms[i], d_md[i]};
  endfunction

  // Per-cycle vectors for DELAY_NR=4, READY_REG=0 starting empty.
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic          e_sr;
    int            e_occ;
  } vec_t;

  function automatic vec_t mkv(input logic v, input logic [DW-1:0] d, input logic mr,
                               input logic e_mv, input logic [DW-1:0] e_md,
                               input logic e_sr, input int e_occ);
    vec_t r;
    r.v = v; r.d = d; r.mr = mr;
    r.e_mv = e_mv; r.e_md = e_md; r.e_sr = e_sr; r.e_occ = e_occ;
    return r;
  endfunction

  vec_t tbl [16];
  int   acc [2];
  int   nout [2];

  initial begin
    // Fill: four beats into a stalled sink, release, a mid-stream stall with
    // a bubble, then drain.
    tbl[0]  = mkv(1, 64'hA0, 0, 0, 64'h0,  1, 0);
    tbl[1]  = mkv(1, 64'hA1, 0, 0, 64'h0,  1, 1);
    tbl[2]  = mkv(1, 64'hA2, 0, 0, 64'h0,  1, 2);
    tbl[3]  = mkv(1, 64'hA3, 0, 0, 64'h0,  1, 3);
    tbl[4]  = mkv(1, 64'hA4, 0, 1, 64'hA0, 0, 4);
    tbl[5]  = mkv(1, 64'hA4, 0, 1, 64'hA0, 0, 4);
    tbl[6]  = mkv(1, 64'hA4, 1, 1, 64'hA0, 1, 4);
    tbl[7]  = mkv(0, 64'h0,  1, 1, 64'hA1, 1, 4);
    tbl[8]  = mkv(0, 64'h0,  1, 1, 64'hA2, 1, 3);
    tbl[9]  = mkv(0, 64'h0,  0, 1, 64'hA3, 1, 2);
    tbl[10] = mkv(1, 64'hA5, 0, 1, 64'hA3, 1, 2);
    tbl[11] = mkv(0, 64'h0,  1, 1, 64'hA3, 1, 3);
    tbl[12] = mkv(0, 64'h0,  1, 1, 64'hA4, 1, 2);
    tbl[13] = mkv(0, 64'h0,  1, 0, 64'h0,  1, 1);
    tbl[14] = mkv(0, 64'h0,  1, 1, 64'hA5, 1, 1);
    tbl[15] = mkv(0, 64'h0,  1, 0, 64'h0,  1, 0);

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drv(i, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_m_valid", d_mv[i], 0);
      chk("reset_s_ready", d_sr[i], 0);
      chk("reset_occupancy", d_occ[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rr1_ready_after_release", d_sr[1], 1);

    // Vector table on the READY_REG=0 instance.
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      drv(0, tbl[r].v, tbl[r].d, 0, tbl[r].mr);
      #1;
      chk($sformatf("tbl%0d_m_valid", r), d_mv[0], tbl[r].e_mv);
      chk($sformatf("tbl%0d_s_ready", r), d_sr[0], tbl[r].e_sr);
      chk($sformatf("tbl%0d_occupancy", r), d_occ[0], tbl[r].e_occ);
      if (tbl[r].e_mv) chk($sformatf("tbl%0d_beat", r), out_beat(0), mk_beat(tbl[r].e_md, 0));
    end

    // Back-to-back stream 0..15, tlast on 15, sink always ready.
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      drv(0, (c < 16), DW'(c), (c == 15), 1);
      #1;
      chk("stream_s_ready", d_sr[0], 1);
      chk("stream_m_valid", d_mv[0], (c >= 4 && c < 20));
      if (c >= 4 && c < 20) chk("stream_beat", out_beat(0), mk_beat(DW'(c - 4), (c - 4) == 15));
    end

    // Stalled sink, continuous input on both instances.
    acc[0] = 0;
    acc[1] = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) drv(i, 1, 64'h100 + DW'(acc[i]), 0, 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stall%0d_s_ready", i), d_sr[i], (i == 0) ? (c < 4) : (c < 5));
        if (d_sr[i]) acc[i]++;
        if (c >= 4) begin
          chk($sformatf("stall%0d_m_valid", i), d_mv[i], 1);
          chk($sformatf("stall%0d_hold_data", i), d_md[i], 64'h100);
        end
      end
    end
    chk("stall_accepted_rr0", acc[0], 4);
    chk("stall_accepted_rr1", acc[1], 5);
    chk("stall_occupancy_rr0", d_occ[0], 4);
    chk("stall_occupancy_rr1", d_occ[1], 5);

    // Release the sink and drain; READY_REG=1 ready must not follow tready.
    nout[0] = 0;
    nout[1] = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) drv(i, 0, 0, 0, 1);
      #1;
      if (c == 0) begin
        chk("rr0_ready_follows_sink", d_sr[0], 1);
        chk("rr1_ready_registered", d_sr[1], 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (d_mv[i]) begin
          chk($sformatf("drain%0d_beat", i), out_beat(i), mk_beat(64'h100 + DW'(nout[i]), 0));
          nout[i]++;
        end
      end
    end
    chk("drain_count_rr0", nout[0], acc[0]);
    chk("drain_count_rr1", nout[1], acc[1]);

    // Reset with three beats held.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) drv(i, 1, 64'h200 + DW'(c), 0, 0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) drv(i, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 2; i++) chk("prereset_occupancy", d_occ[i], 3);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drv(i, 1, 64'h2FF, 0, 0);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("in_reset_s_ready", d_sr[i], 0);
      chk("in_reset_m_valid", d_mv[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) drv(i, 0, 0, 0, 1);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("postreset_m_valid", d_mv[i], 0);
      chk("postreset_occupancy", d_occ[i], 0);
    end
    chk("postreset_rr1_ready_low", d_sr[1], 0);
    @(negedge clk);
    #1;
    chk("postreset_rr1_ready_high", d_sr[1], 1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) chk("discarded_beats_absent", d_mv[i], 0);
    end

    // Random phase.
    start_rand = 1'b1;
    wait (rand_done[0] && rand_done[1] && rand_done[2] && rand_done[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Random instances with a queue-based reference model.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 4; k++) begin : g_rand
    localparam int D  = (k < 2) ? 1 : 7;
    localparam int RR = k % 2;
    localparam int OW = $clog2(D + 2);

    logic          sv, sr, sl, su, mv, mr, ml, mu;
    logic [DW-1:0] sd, md;
    logic [SW-1:0] ss, sk, ms, mk;
    logic [OW-1:0] occ;

    axis_delay_line #(
      .AXIS_DATA_WIDTH (DW), .AXIS_USER_WIDTH (1), .DELAY_NR (D), .READY_REG (RR)
    ) u_dut (
      .clk_i (clk), .rst_n_i (rst_n),
      .s_axis_tvalid (sv), .s_axis_tdata (sd), .s_axis_tstrb (ss),
      .s_axis_tkeep (sk), .s_axis_tuser (su), .s_axis_tlast (sl),
      .s_axis_tready (sr),
      .m_axis_tvalid (mv), .m_axis_tready (mr), .m_axis_tdata (md),
      .m_axis_tstrb (ms), .m_axis_tkeep (mk), .m_axis_tuser (mu),
      .m_axis_tlast (ml), .occupancy_o (occ)
    );

    logic [BW-1:0] q_beat [$];
    int            q_t [$];

    initial begin
      int            cyc, sent, recv;
      logic          hs_in, hs_out, stall_prev;
      logic [BW-1:0] ob, prev_beat;
      logic [DW-1:0] nd;

      rand_done[k] = 1'b0;
      sv = 0; sd = '0; ss = '0; sk = '0; su = 0; sl = 0; mr = 0;
      cyc = 0; sent = 0; recv = 0;
      hs_in = 0; stall_prev = 0; prev_beat = '0;
      wait (start_rand);

      while (recv < NBEATS && cyc < BUDGET) begin
        @(negedge clk);
        if (!sv || hs_in) begin
          if (sent < NBEATS && $urandom_range(0, 99) < 70) begin
            nd = {$urandom, $urandom};
            sv = 1; sd = nd; ss = f_strb(nd); sk = f_keep(nd); su = f_user(nd); sl = nd[20];
          end else begin
            sv = 0;
          end
        end
        mr = ($urandom_range(0, 99) < 65);
        #2;
        hs_in  = sv & sr;
        hs_out = mv & mr;
        ob     = {ml, mu, mk, ms, md};

        chk($sformatf("rand%0d_occupancy", k), occ, q_beat.size());
        if (stall_prev) begin
          chk($sformatf("rand%0d_stall_valid", k), mv, 1);
          chk($sformatf("rand%0d_stall_beat", k), ob, prev_beat);
        end
        if (hs_out) begin
          if (q_beat.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand%0d_spurious_beat: actual %0h, required no beat", k, ob);
          end else begin
            chk($sformatf("rand%0d_beat", k), ob, q_beat[0]);
            chk($sformatf("rand%0d_latency_min", k), (cyc - q_t[0]) >= D, 1);
            void'(q_beat.pop_front());
            void'(q_t.pop_front());
          end
          recv++;
        end
        if (hs_in) begin
          q_beat.push_back(mk_beat(sd, sl));
          q_t.push_back(cyc);
          sent++;
        end
        stall_prev = mv & ~mr;
        prev_beat  = ob;
        cyc++;
      end
      chk($sformatf("rand%0d_beats_received", k), recv, NBEATS);
      chk($sformatf("rand%0d_queue_empty", k), q_beat.size(), 0);
      rand_done[k] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/axis_delay_line.md
Name: axis_delay_line

Overview:
Parametrised AXI-Stream delay line that holds every beat for a fixed minimum of DELAY_NR cycles. It applies correct backpressure, so no beat is lost or duplicated when the sink stalls. It sits inline on any AXIS path (data, strobe, keep, user, last) that needs fixed-latency alignment with a parallel pipeline. It also reports its current occupancy.

Parameters:
AXIS_DATA_WIDTH  64  tdata width in bits; multiple of 8
AXIS_USER_WIDTH  1  tuser width in bits; 1 or more
DELAY_NR  1  number of register stages = minimum latency in cycles; must be 1 or more, 0 is an elaboration error
READY_REG  0  0: s_axis_tready is combinational from downstream; 1: s_axis_tready comes straight from a flop, with a one-entry skid buffer at the input stage

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  synchronous reset, active low
s_axis_tvalid  input  1  upstream valid
s_axis_tdata  input  AXIS_DATA_WIDTH  upstream data
s_axis_tstrb  input  AXIS_DATA_WIDTH/8  upstream strobe
s_axis_tkeep  input  AXIS_DATA_WIDTH/8  upstream keep
s_axis_tuser  input  AXIS_USER_WIDTH  upstream user sideband
s_axis_tlast  input  1  upstream packet end
s_axis_tready  output  1  upstream ready
m_axis_tvalid  output  1  downstream valid
m_axis_tdata  output  AXIS_DATA_WIDTH  downstream data
m_axis_tstrb  output  AXIS_DATA_WIDTH/8  downstream strobe
m_axis_tkeep  output  AXIS_DATA_WIDTH/8  downstream keep
m_axis_tuser  output  AXIS_USER_WIDTH  downstream user
m_axis_tlast  output  1  downstream packet end
occupancy_o  output  $clog2(DELAY_NR+2)  number of beats currently held

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low on rst_n_i.
- Reset clears all stage valid bits and the skid valid bit, and zeroes occupancy_o.
- Data, strb, keep, user and last registers are not reset.
- While rst_n_i is low: m_axis_tvalid=0, s_axis_tready=0, occupancy_o=0.
  - READY_REG=1: the ready flop resets to 0 and reads 1 on the first cycle after release.
- Pipeline: stages 0..DELAY_NR-1, each holding a valid bit plus the full beat (data, strb, keep, user, last). Stage DELAY_NR-1 drives the m_axis_* outputs directly.
- Handshake: a transfer occurs when tvalid & tready are both high on a rising edge.
- Stage advance rule:
  - adv[DELAY_NR-1] = m_axis_tready | ~valid[DELAY_NR-1]
  - adv[i] = adv[i+1] | ~valid[i]
  - When stage i advances, it loads stage i-1 (or the input for i=0) and takes over its valid bit.
- Bubbles collapse: an empty stage never blocks upstream movement.
- Latency: a beat accepted at edge T is first presented on m_axis_tvalid in the cycle after edge T+DELAY_NR-1, i.e. exactly DELAY_NR cycles of registering. It is never presented earlier. A stalled sink may make it later.
- Throughput: 1 beat per clock when m_axis_tready is held high, in both READY_REG modes.
- AXIS stability: while m_axis_tvalid=1 and m_axis_tready=0, every m_axis_* output holds constant. This follows from the advance rule.
- READY_REG=0:
  - s_axis_tready = adv[0] (gated low in reset).
  - Capacity is DELAY_NR beats.
  - The combinational path m_axis_tready -> s_axis_tready is allowed.
- READY_REG=1:
  - s_axis_tready is a flop: 1 when the skid buffer is empty.
  - If an input beat is accepted while adv[0]=0, it is captured in the skid buffer. Ready drops on the next cycle.
  - The skid beat has priority into stage 0. Input never bypasses it, so order is preserved.
  - Capacity is DELAY_NR+1 beats.
  - There is no combinational path from m_axis_tready to s_axis_tready.
- occupancy_o:
  - Registered count of valid stages plus the skid buffer.
  - Increments on input accept, decrements on output accept, unchanged when both occur in the same cycle.
  - Never exceeds DELAY_NR+READY_REG.
- Empty: m_axis_tvalid=0 and occupancy_o=0.
- Full: s_axis_tready=0 (READY_REG=0: combinationally once all stages are valid and m_axis_tready=0).
- Reset mid-stream: all held beats are discarded and never emitted. Input presented during reset is not accepted.
- The block never inspects, reorders or modifies tlast, tuser, tstrb or tkeep. They travel with their beat.

Decomposition:
- Package axis_pkg holds:
  - a beat-width helper function (data + 2·(data/8) + user + 1)
  - pack/unpack functions that flatten the beat into one vector, so each stage is a single register
- Natural sub-module: axis_reg_slice, one stage with a valid bit, a beat register and the adv logic. It is instantiated DELAY_NR times in a generate loop.
- The skid buffer lives in the top level.

Test Plan:
1. DELAY_NR=4, READY_REG=0, m_axis_tready=1, 16 back-to-back beats with tdata=0..15 and tlast on 15 -> first m_axis_tvalid exactly 4 cycles after the first accept; one beat per cycle; order 0..15; tlast only on beat 15.
2. DELAY_NR=4, m_axis_tready=0, continuous input -> READY_REG=0 accepts 4 beats then ready=0 with occupancy_o=4; READY_REG=1 accepts 5 with occupancy_o=5. m_axis_tdata stays constant throughout the stall.
3. Input valid every other cycle, m_axis_tready low for 10 cycles then high -> bubbles collapse; output beats are back-to-back after release; no loss or duplication.
4. Occupancy 3, rst_n_i low for one cycle -> next cycle m_axis_tvalid=0 and occupancy_o=0; the pre-reset beats never appear; READY_REG=1 ready returns to 1 one cycle after release.
5. DELAY_NR=1 and 7, both READY_REG values, 10k beats with random valid/ready, tuser/tstrb/tkeep = f(tdata) -> scoreboard exact match; sidebands stay aligned; latency is never below DELAY_NR.
6. READY_REG=1 -> structural/formal check confirms no combinational path from m_axis_tready to s_axis_tready; AXIS stability assertions hold on both interfaces.
